axis_pkt_gen: RTL
=================

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the stream data width in bits.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, meaning the width of the packet-length and packet-count fields.
REQ-003 The block SHALL have parameter GAP_WIDTH, default 8, meaning the width of the inter-packet gap field.
REQ-004 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: requests a run; sampled only in IDLE.
REQ-007 The block SHALL have port pkt_len, input, LEN_WIDTH bits: number of beats per packet.
REQ-008 The block SHALL have port num_pkts, input, LEN_WIDTH bits: number of packets per run.
REQ-009 The block SHALL have port gap, input, GAP_WIDTH bits: number of idle cycles between packets.
REQ-010 The block SHALL have port m_data, output, DATA_WIDTH bits: stream payload.
REQ-011 The block SHALL have port m_valid, output, 1 bit: stream valid.
REQ-012 The block SHALL have port m_last, output, 1 bit: marks the final beat of a packet.
REQ-013 The block SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a run completes.

Function
REQ-016 The block SHALL implement a 3-state FSM: IDLE, SEND and GAP.
REQ-017 In IDLE, the block SHALL latch pkt_len, num_pkts and gap on the edge where start is high and both pkt_len and num_pkts are nonzero, then enter SEND; m_valid SHALL be high on the next cycle (1-cycle latency).
REQ-018 A start with pkt_len=0 or num_pkts=0 SHALL be ignored: the state stays IDLE and done is not pulsed.
REQ-019 A start while busy SHALL be ignored; changes to the config inputs during a run SHALL have no effect.
REQ-020 A beat transfers only on the edge where m_valid and m_ready are both high.
REQ-021 m_valid SHALL be high in SEND and low in IDLE and GAP.
REQ-022 Once m_valid is asserted, it SHALL NOT deassert before a transfer.
REQ-023 While m_valid is high and m_ready is low, m_data and m_last SHALL hold stable.
REQ-024 m_valid SHALL NOT depend combinationally on m_ready.
REQ-025 m_data SHALL equal a run beat counter that starts at 0 for each run, increments by 1 per transfer, and wraps modulo 2^DATA_WIDTH.
REQ-026 m_last SHALL be high exactly when the beat index within the packet equals latched pkt_len-1; pkt_len=1 SHALL give m_last high on every beat.
REQ-027 On the last-beat transfer of the final packet (packet index = num_pkts-1), the FSM SHALL go to IDLE and done SHALL pulse high for the following cycle.
REQ-028 On the last-beat transfer of any other packet, the FSM SHALL stay in SEND (back-to-back, no bubble) if gap=0, and SHALL otherwise go to GAP.
REQ-029 In GAP, m_valid SHALL be low for exactly gap cycles, then the FSM SHALL return to SEND with the beat index reset to 0.
REQ-030 Beat, packet and gap counters SHALL be LEN_WIDTH/GAP_WIDTH bits wide, with comparisons against latched values only; pkt_len and num_pkts up to 2^LEN_WIDTH-1 SHALL be supported without overflow.

Reset
REQ-031 While areset is sampled high, the state SHALL be IDLE and m_valid, m_last, m_data, busy, done and all counters SHALL be 0 on the following cycle.
REQ-032 Reset mid-packet SHALL abort the run with no done pulse; the downstream sees m_valid drop without a transfer, which is permitted only under reset.
REQ-033 The first start SHALL be accepted on the first edge after areset is deasserted.

Structure
REQ-034 A shared package axis_pkg SHALL hold the FSM state encodings and default DATA_WIDTH, LEN_WIDTH and GAP_WIDTH constants reused by the stream blocks.
REQ-035 The block SHALL be a single module with no sub-module.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Scenario: start with len=4, pkts=2, gap=0, m_ready=1 -> m_data 0..7, m_last on beats 3 and 7, m_valid continuous for 8 cycles, then done pulse.
REQ-038 Scenario: len=3, pkts=3, gap=2 -> exactly 2 low-valid cycles after beats 2 and 5, done after beat 8.
REQ-039 Scenario: random m_ready backpressure (50%), len=5, pkts=4 -> m_data/m_last stable while stalled, 20 beats, sequence 0..19 unbroken.
REQ-040 Scenario: start with len=0, and separately start while busy -> no state change, no done, and the run in progress is unaffected.
REQ-041 Scenario: areset asserted at beat 2 of len=8 -> the next cycle shows m_valid=0 and busy=0; a restart produces m_data starting from 0.
REQ-042 Scenario: len=1, pkts=3, gap=1 -> m_last high on every beat, pattern valid/idle/valid/idle/valid.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream blocks: FSM state encodings and
// default bus and field widths.
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pkt_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_GAP_WIDTH  = 8;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits num_pkts packets of pkt_len beats carrying
// a per-run incrementing counter, separated by gap idle cycles.
module axis_pkt_gen
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [LEN_WIDTH-1:0]  num_pkts,
    input  logic [GAP_WIDTH-1:0]  gap,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    pkt_state_t            state_reg, state_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic [LEN_WIDTH-1:0]  pkts_reg, pkts_next;
    logic [GAP_WIDTH-1:0]  gap_reg, gap_next;
    logic [LEN_WIDTH-1:0]  beat_reg, beat_next;
    logic [LEN_WIDTH-1:0]  pkt_idx_reg, pkt_idx_next;
    logic [GAP_WIDTH-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  last_reg, last_next;
    logic                  valid_reg, valid_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg   <= ST_IDLE;
            len_reg     <= '0;
            pkts_reg    <= '0;
            gap_reg     <= '0;
            beat_reg    <= '0;
            pkt_idx_reg <= '0;
            gap_cnt_reg <= '0;
            data_reg    <= '0;
            last_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            pkts_reg    <= pkts_next;
            gap_reg     <= gap_next;
            beat_reg    <= beat_next;
            pkt_idx_reg <= pkt_idx_next;
            gap_cnt_reg <= gap_cnt_next;
            data_reg    <= data_next;
            last_reg    <= last_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        pkts_next    = pkts_reg;
        gap_next     = gap_reg;
        beat_next    = beat_reg;
        pkt_idx_next = pkt_idx_reg;
        gap_cnt_next = gap_cnt_reg;
        data_next    = data_reg;
        last_next    = last_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && (pkt_len != '0) && (num_pkts != '0)) begin
                    len_next     = pkt_len;
                    pkts_next    = num_pkts;
                    gap_next     = gap;
                    beat_next    = '0;
                    pkt_idx_next = '0;
                    gap_cnt_next = '0;
                    data_next    = '0;
                    last_next    = (pkt_len == LEN_WIDTH'(1));
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                // valid is always high in SEND, so ready alone marks a transfer
                if (m_ready) begin
                    data_next = data_reg + DATA_WIDTH'(1);
                    if (last_reg) begin
                        beat_next = '0;
                        last_next = 1'b0;
                        if (pkt_idx_reg == pkts_reg - LEN_WIDTH'(1)) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            pkt_idx_next = pkt_idx_reg + LEN_WIDTH'(1);
                            if (gap_reg == '0) begin
                                last_next = (len_reg == LEN_WIDTH'(1));
                            end else begin
                                state_next   = ST_GAP;
                                gap_cnt_next = GAP_WIDTH'(1);
                            end
                        end
                    end else begin
                        beat_next = beat_reg + LEN_WIDTH'(1);
                        last_next = (beat_reg + LEN_WIDTH'(1) == len_reg - LEN_WIDTH'(1));
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == gap_reg) begin
                    state_next = ST_SEND;
                    beat_next  = '0;
                    last_next  = (len_reg == LEN_WIDTH'(1));
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_WIDTH'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        valid_next = (state_next == ST_SEND);
        busy_next  = (state_next != ST_IDLE);
    end

    assign m_data  = data_reg;
    assign m_valid = valid_reg;
    assign m_last  = last_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
